inst_fetch: RTL
===============

# inst_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the fetch PC, drives the sram-like instruction port (one outstanding request), and loads the F/D pipeline register (`instrD`, `pcD`) that the decode-stage controller consumes. It supports:

- branch/jump redirects that preserve the delay slot;
- exception/eret redirects that cancel in-flight fetches;
- decode stalls and flushes;
- misaligned-PC fault tagging.

## Interface
- `RESET_PC`, default 32'hBFC00000, fetch address after reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_req`  out  1  sram-like request valid.
- `inst_wr`  out  1  tied 0.
- `inst_size`  out  2  tied 2'b10 (word).
- `inst_addr`  out  32  request address (`req_addr` register).
- `inst_wdata`  out  32  tied 0.
- `inst_addr_ok`  in  1  request accepted.
- `inst_data_ok`  in  1  read data valid.
- `inst_rdata`  in  32  read data.
- `stallD`  in  1  hold the F/D register.
- `flushD`  in  1  clear the F/D register.
- `br_redirect`  in  1  decode-stage branch/jump taken.
- `br_target`  in  32  branch/jump target.
- `exc_redirect`  in  1  exception/eret redirect; discards the in-flight fetch.
- `exc_pc`  in  32  handler or EPC address.
- `instrD`  out  32  F/D instruction.
- `pcD`  out  32  F/D PC.
- `validD`  out  1  F/D holds a real instruction.
- `adelD`  out  1  F/D entry is an instruction-address fault.

## Operation
- Registers:
  - `pcF`
  - `req_addr`
  - `hold_buf[31:0]`
  - `cancel`: the in-flight response is to be discarded.
  - `br_pend` + `br_tgt`: latched next-PC override.
  - state ∈ {IDLE, REQ, WAIT, HOLD, FAULT}
  - F/D register
- Reset values:
  - `pcF = RESET_PC`; state IDLE.
  - `cancel`, `br_pend`, `validD`, `adelD` = 0.
  - `instrD = 0`; `pcD = 0`.
  - `br_tgt = 0`; `hold_buf = 0`; `req_addr = 0`.
  - `inst_req = 0`.
- Issue step, used from IDLE and on every completion:
  - If the new `pcF[1:0] != 0` → FAULT.
  - Otherwise → REQ, with `req_addr <= pcF`.
- REQ:
  - `inst_req = 1`.
  - `req_addr` is held stable until `inst_addr_ok`; the request is never withdrawn.
  - On `inst_addr_ok` → WAIT.
- WAIT: on `inst_data_ok`:
  - If `cancel`: discard the data, clear `cancel`, run the issue step.
  - Otherwise, if `!stallD`: load F/D (`instrD = inst_rdata`, `pcD = req_addr`, `validD = 1`), advance the PC, run the issue step.
  - Otherwise: `hold_buf <= inst_rdata` → HOLD.
- HOLD: when `!stallD`, load F/D from `hold_buf`, advance the PC, run the issue step.
- FAULT:
  - No request is issued.
  - When `!stallD`, load F/D once with `instrD = 0`, `pcD = pcF`, `validD = 1`, `adelD = 1`.
  - Afterwards, while `!stallD`, bubbles are loaded.
  - FAULT exits only on `exc_redirect`.
- Advancing the PC means `pcF <= br_redirect ? br_target : (br_pend ? br_tgt : pcF + 4)`, then `br_pend` is cleared.
- `br_redirect` while no delivery occurs this cycle: `br_pend <= 1`, `br_tgt <= br_target`. The instruction currently being fetched is the delay slot and is delivered normally. `br_redirect` is ignored in FAULT.
- `exc_redirect` has highest priority:
  - `pcF <= exc_pc`; `br_pend` cleared; F/D cleared (`validD = 0`, `adelD = 0`, `instrD = 0`).
  - In REQ or in WAIT without `data_ok`: `cancel <= 1`, state unchanged.
  - In WAIT with `data_ok` the same cycle: data discarded.
  - In HOLD, FAULT or IDLE: buffer dropped and the issue step runs on `exc_pc`.
- F/D update priority:
  1. `exc_redirect` / `flushD` → cleared (bubble).
  2. `stallD` → hold.
  3. Delivery → load.
  4. Otherwise → bubble (`validD = 0`, `instrD = 0`, i.e. a NOP).

## Timing
- Minimum fetch-to-D latency: `addr_ok` in the first REQ cycle plus `data_ok` in the next cycle gives `instrD` on the edge ending the `data_ok` cycle.
- Throughput: at most one instruction per 2 cycles.
- IDLE lasts exactly 1 cycle after reset deasserts.
- `inst_req` is a pure function of state (REQ only); it has no combinational path from `stallD` or the redirect inputs.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFFFFFC + 4 → 0).
- Asserting `rst` mid-transaction returns to the reset values immediately. Any late `inst_data_ok` arriving in IDLE is ignored.

## Test plan
- Reset with the slave returning `addr_ok` immediately and `data_ok` 1 cycle later → `inst_addr` = BFC00000, BFC00004, BFC00008, …; `pcD` follows with `validD = 1`; bubbles in between.
- `addr_ok` delayed 3 cycles → `inst_req` held high with `inst_addr` constant for 4 cycles; exactly one request accepted.
- `data_ok` while `stallD = 1` for 2 cycles → HOLD, F/D unchanged; the load on the first `!stallD` edge has `instrD` = the captured data; no new request before that.
- Branch at `pcD` = BFC00010 asserts `br_redirect` to BFC00100 while the fetch of BFC00014 is in WAIT → BFC00014 delivered, next `inst_addr` = BFC00100.
- `exc_redirect` to BFC00380 during WAIT → the returning data is discarded (`validD` stays 0); the next request address is BFC00380.
- `exc_pc` = BFC00382 → no `inst_req`; one F/D entry with `adelD = 1`, `pcD` = BFC00382, `instrD = 0`; fetch stays idle until the next `exc_redirect`.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage of the five-stage MIPS pipeline. Owns the fetch PC,
//   drives an sram-like instruction port with one outstanding request, and
//   loads the F/D pipeline register consumed by the decode stage.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   inst_req/wr/size/addr/wdata   sram-like request side (read-only, word)
//   inst_addr_ok/data_ok/rdata    sram-like handshake and read data
//   stallD, flushD           decode-stage hold / clear of the F/D register
//   br_redirect, br_target   taken branch/jump (delay slot preserved)
//   exc_redirect, exc_pc     exception/eret redirect (cancels in-flight fetch)
//   instrD, pcD, validD, adelD    F/D register contents
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        exc_redirect,
  input  logic [31:0] exc_pc,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        adelD
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc_f, req_addr, hold_buf, br_tgt;
  logic        cancel, br_pend, fault_done;

  logic        deliver, deliver_fault, advance, issue;
  logic [31:0] deliver_instr, deliver_pc, pc_adv, issue_pc;

  // The request line depends on the state register only.
  assign inst_req   = (state == REQ);
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'd0;
  assign inst_addr  = req_addr;

  // A live branch overrides a latched one; otherwise fall through sequentially.
  assign pc_adv = br_redirect ? br_target : (br_pend ? br_tgt : pc_f + 32'd4);

  // Delivery into F/D this cycle. An exception redirect suppresses any delivery.
  // The fault entry is delivered once and does not advance the PC.
  always_comb begin
    deliver       = 1'b0;
    deliver_fault = 1'b0;
    deliver_instr = hold_buf;
    deliver_pc    = req_addr;
    if (!exc_redirect && !stallD) begin
      case (state)
        WAIT: begin
          if (inst_data_ok && !cancel) begin
            deliver       = 1'b1;
            deliver_instr = inst_rdata;
          end
        end
        HOLD: deliver = 1'b1;
        FAULT: begin
          if (!fault_done) begin
            deliver       = 1'b1;
            deliver_fault = 1'b1;
            deliver_instr = 32'd0;
            deliver_pc    = pc_f;
          end
        end
        default: ;
      endcase
    end
    advance = deliver && (state != FAULT);
  end

  // Next-state logic. The issue step picks REQ or FAULT from the address that
  // the PC is about to hold; a request already on the bus in REQ is never
  // withdrawn, so an exception there only marks its response for discard.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_pc   = pc_f;
    if (exc_redirect) begin
      case (state)
        REQ:  if (inst_addr_ok) state_next = WAIT;
        WAIT: begin
          if (inst_data_ok) begin
            issue    = 1'b1;
            issue_pc = exc_pc;
          end
        end
        default: begin
          issue    = 1'b1;
          issue_pc = exc_pc;
        end
      endcase
    end else begin
      case (state)
        IDLE: issue = 1'b1;
        REQ:  if (inst_addr_ok) state_next = WAIT;
        WAIT: begin
          if (inst_data_ok) begin
            if (cancel) begin
              issue = 1'b1;
            end else if (!stallD) begin
              issue    = 1'b1;
              issue_pc = pc_adv;
            end else begin
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stallD) begin
            issue    = 1'b1;
            issue_pc = pc_adv;
          end
        end
        default: ;
      endcase
    end
    if (issue) state_next = (issue_pc[1:0] != 2'b00) ? FAULT : REQ;
  end

  // Fetch control state: FSM, PC, request address, buffer, cancel and branch latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc_f       <= RESET_PC;
      req_addr   <= 32'd0;
      hold_buf   <= 32'd0;
      cancel     <= 1'b0;
      br_pend    <= 1'b0;
      br_tgt     <= 32'd0;
      fault_done <= 1'b0;
    end else begin
      state <= state_next;
      if (issue && (issue_pc[1:0] == 2'b00)) req_addr <= issue_pc;
      if ((state == WAIT) && (state_next == HOLD)) hold_buf <= inst_rdata;

      if (exc_redirect) begin
        pc_f    <= exc_pc;
        br_pend <= 1'b0;
      end else if (advance) begin
        pc_f    <= pc_adv;
        br_pend <= 1'b0;
      end else if (br_redirect && (state != FAULT)) begin
        br_pend <= 1'b1;
        br_tgt  <= br_target;
      end

      // Only one response can be outstanding, so a single flag suffices.
      if (exc_redirect && ((state == REQ) || ((state == WAIT) && !inst_data_ok)))
        cancel <= 1'b1;
      else if ((state == WAIT) && inst_data_ok)
        cancel <= 1'b0;

      if (issue)
        fault_done <= 1'b0;
      else if (deliver_fault)
        fault_done <= 1'b1;
    end
  end

  // F/D register: clear beats hold, hold beats load, otherwise a bubble.
  // pcD is left untouched by bubbles since validD qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD <= 32'd0;
      pcD    <= 32'd0;
      validD <= 1'b0;
      adelD  <= 1'b0;
    end else if (exc_redirect || flushD) begin
      instrD <= 32'd0;
      validD <= 1'b0;
      adelD  <= 1'b0;
    end else if (stallD) begin
      instrD <= instrD;
    end else if (deliver) begin
      instrD <= deliver_instr;
      pcD    <= deliver_pc;
      validD <= 1'b1;
      adelD  <= deliver_fault;
    end else begin
      instrD <= 32'd0;
      validD <= 1'b0;
      adelD  <= 1'b0;
    end
  end

endmodule
